keccak_arbiter: RTL and testbench
=================================

# keccak_arbiter

Sequences and shares one `keccak` hash core between two independent message requesters. Arbitrates at message boundaries with round-robin priority and pulses the core's clear before each message. Forwards 32-bit words under the core's `buffer_full` back-pressure, captures the 512-bit digest on `out_ready`, and returns it to the owning requester. A watchdog aborts messages whose digest never arrives. Sits directly in front of the `keccak` core.

## Interface
Parameters:
- `TIMEOUT`, default 1024: maximum cycles waited for `core_out_ready` after the last word; range 1..65535.

Ports:
- `clk`  in  1  clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `r0_valid`, `r1_valid`  in  1  requester word valid.
- `r0_data`, `r1_data`  in  32  message word; first byte in bits [31:24].
- `r0_last`, `r1_last`  in  1  word is the final word of the message.
- `r0_byte_num`, `r1_byte_num`  in  2  valid bytes in the final word; 0 means no data bytes.
- `r0_ready`, `r1_ready`  out  1  word accepted when valid && ready.
- `digest`  out  512  captured digest, held while `digest_valid` is high.
- `digest_valid`  out  1  digest available.
- `digest_id`  out  1  requester that owns `digest`.
- `digest_ack`  in  1  consumer takes the digest.
- `timeout_err`  out  1  one-cycle pulse on watchdog abort.
- `err_id`  out  1  requester whose message was aborted; valid with `timeout_err`.
- `core_reset`  out  1  active-high clear to the core.
- `core_in`  out  32  core data input.
- `core_in_ready`  out  1  core data strobe.
- `core_is_last`  out  1  core final-word marker.
- `core_byte_num`  out  2  core final-word byte count.
- `core_buffer_full`  in  1  core cannot accept a word.
- `core_out`  in  512  core digest.
- `core_out_ready`  in  1  core digest valid; stays high until the next `core_reset`.

## Operation
- FSM states: IDLE, CLEAR, STREAM, WAIT, DELIVER.
- IDLE:
  - If any `rX_valid` is high, latch `grant`, go to CLEAR.
  - If both are high, grant goes to `prio`. Otherwise grant goes to whichever is valid.
- CLEAR:
  - `core_reset`=1 for exactly one cycle, then go to STREAM.
- STREAM:
  - `rG_ready = !core_buffer_full`, where G is the granted requester. The other requester's ready is 0.
  - `core_in_ready = rG_valid && rG_ready`.
  - `core_in`, `core_is_last`, `core_byte_num` are combinational muxes of G's inputs. They are zero when nothing is transferred.
  - A transfer with `rG_last`=1 goes to WAIT and clears `wcnt`.
- WAIT:
  - `wcnt` increments each cycle.
  - `core_out_ready`=1: register `core_out` into `digest`, go to DELIVER.
  - Otherwise, if `wcnt == TIMEOUT-1`: pulse `timeout_err` with `err_id`=G, assert `core_reset` for one cycle, set `prio = ~G`, go to IDLE.
- DELIVER:
  - `digest_valid`=1 and `digest_id`=G.
  - `digest_ack`=1: set `prio = ~G`, go to IDLE. `digest_valid` falls the next cycle.
- `core_out_ready` is ignored outside WAIT.
- Requester gaps (`rG_valid`=0 mid-message) stall with no side effects.
- A non-granted requester holding `valid` waits with ready=0. Its data must remain stable.

## Timing
- Reset (`reset`=0):
  - state=IDLE, `prio`=0, `grant`=0, `wcnt`=0, `digest`=0.
  - All ready, `digest_valid`, `timeout_err`, `core_in_ready` are 0.
  - `core_reset`=1 on every cycle `reset` is low. This clears the core mid-message too.
  - The first cycle after release is IDLE.
- Start latency: valid seen in IDLE at edge t. CLEAR occupies cycle t+1. Earliest word transfer is cycle t+2.
- Back-pressure: `rG_ready` follows `core_buffer_full` combinationally in the same cycle. A word is never presented to the core while it is full.
- Digest latency: `digest_valid` rises one cycle after `core_out_ready` is sampled in WAIT.
- DELIVER with `digest_ack` already high: one cycle of `digest_valid`. IDLE can re-grant on the following cycle.
- A new `rX_valid` arriving during DELIVER is not granted until IDLE.
- A single-word message (`last` on the first transfer) goes STREAM→WAIT after one transfer.
- `wcnt` is 16 bits wide and does not wrap before timeout.

## Structure
- Shared package `keccak_pkg`:
  - state enum `arb_state_t` (IDLE/CLEAR/STREAM/WAIT/DELIVER);
  - `WORD_W`=32, `DIGEST_W`=512, `BYTE_NUM_W`=2.
- One sub-module, `keccak_rr_pick`: two-way round-robin picker (valid[1:0], prio → grant), purely combinational.
- FSM, watchdog counter and digest register stay in `keccak_arbiter`.

## Test plan
- **Single message.** r0 sends "Hell","o, w","orld","!   " with last, byte_num=1. Required response:
  - `core_reset` pulses one cycle before the first `core_in_ready`;
  - exactly 4 core strobes;
  - `digest` equals a direct-core run on the same stimulus; `digest_id`=0.
- **Contention.** r0 and r1 both valid in the same IDLE cycle, `prio`=0.
  - r0 is served first; r1's ready stays 0 throughout.
  - The next grant is r1; digests are returned in order with `digest_id` 0 then 1.
- **Back-pressure.** Hold `core_buffer_full`=1 for 5 cycles mid-message.
  - `r0_ready`=0 and `core_in_ready`=0 for those cycles.
  - No word is lost or duplicated; the word count at the core is 11 for the "The quick brown fox jumps over the lazy dog." stimulus.
- **Zero-byte final word.** Final word with `byte_num`=0 and last after "Hell","o, w","orld".
  - `core_is_last`=1 with `core_byte_num`=0.
  - Digest matches the direct-core result for "Hello, world".
- **Timeout.** TIMEOUT=8 and the core model never raises `out_ready`.
  - `timeout_err` pulses exactly 8 cycles after entering WAIT, with `err_id` equal to the granted requester.
  - `core_reset` pulses; `digest_valid` stays 0; the FSM returns to IDLE.
- **Mid-message reset.** Drive `reset`=0 for 2 cycles during STREAM.
  - All readies drop and `core_reset` is 1 for both cycles; state=IDLE and `prio`=0 after release.
  - A fresh message then produces the correct digest.

Source files
------------

// File: rtl/keccak_pkg.sv
// Shared widths and FSM state type for the keccak core arbiter.
package keccak_pkg;
  localparam int WORD_W     = 32;
  localparam int DIGEST_W   = 512;
  localparam int BYTE_NUM_W = 2;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    STREAM,
    WAIT,
    DELIVER
  } arb_state_t;
endpackage

// File: rtl/keccak_rr_pick.sv
// Two-way round-robin picker: prio breaks a tie, otherwise the lone valid requester wins.
// Purely combinational; zero latency, no backpressure of its own.
module keccak_rr_pick (
  input  logic [1:0] valid,
  input  logic       prio,
  output logic       grant
);
  always_comb begin
    grant = 1'b0;
    if (valid == 2'b11) grant = prio;
    else if (valid[1])  grant = 1'b1;
  end
endmodule

// File: rtl/keccak_arbiter.sv
// Shares one keccak core between two requesters; grant 2 cycles before the first word, digest 1 cycle after out_ready.
// Backpressure: granted ready follows !core_buffer_full combinationally; the loser sees ready=0.
module keccak_arbiter
  import keccak_pkg::*;
#(
  parameter int TIMEOUT = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  r0_valid,
  input  logic [WORD_W-1:0]     r0_data,
  input  logic                  r0_last,
  input  logic [BYTE_NUM_W-1:0] r0_byte_num,
  output logic                  r0_ready,
  input  logic                  r1_valid,
  input  logic [WORD_W-1:0]     r1_data,
  input  logic                  r1_last,
  input  logic [BYTE_NUM_W-1:0] r1_byte_num,
  output logic                  r1_ready,
  output logic [DIGEST_W-1:0]   digest,
  output logic                  digest_valid,
  output logic                  digest_id,
  input  logic                  digest_ack,
  output logic                  timeout_err,
  output logic                  err_id,
  output logic                  core_reset,
  output logic [WORD_W-1:0]     core_in,
  output logic                  core_in_ready,
  output logic                  core_is_last,
  output logic [BYTE_NUM_W-1:0] core_byte_num,
  input  logic                  core_buffer_full,
  input  logic [DIGEST_W-1:0]   core_out,
  input  logic                  core_out_ready
);
  arb_state_t state, state_nxt;

  logic        grant, prio, pick;
  logic [15:0] wcnt;
  logic        load_grant, clr_wcnt, cap_digest, flip_prio;

  logic                  g_valid, g_last;
  logic [WORD_W-1:0]     g_data;
  logic [BYTE_NUM_W-1:0] g_byte_num;
  logic                  timeout_hit;

  keccak_rr_pick u_pick (
    .valid ({r1_valid, r0_valid}),
    .prio  (prio),
    .grant (pick)
  );

  assign g_valid     = grant ? r1_valid    : r0_valid;
  assign g_last      = grant ? r1_last     : r0_last;
  assign g_data      = grant ? r1_data     : r0_data;
  assign g_byte_num  = grant ? r1_byte_num : r0_byte_num;
  assign timeout_hit = (wcnt == 16'(TIMEOUT - 1));

  assign digest_id = grant;
  assign err_id    = grant;

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Reset overrides every state so a mid-message reset also clears the core.
  always_comb begin
    state_nxt     = state;
    r0_ready      = 1'b0;
    r1_ready      = 1'b0;
    core_reset    = 1'b0;
    core_in       = '0;
    core_in_ready = 1'b0;
    core_is_last  = 1'b0;
    core_byte_num = '0;
    digest_valid  = 1'b0;
    timeout_err   = 1'b0;
    load_grant    = 1'b0;
    clr_wcnt      = 1'b0;
    cap_digest    = 1'b0;
    flip_prio     = 1'b0;
    if (!reset) begin
      core_reset = 1'b1;
      state_nxt  = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (r0_valid || r1_valid) begin
            load_grant = 1'b1;
            state_nxt  = CLEAR;
          end
        end
        CLEAR: begin
          core_reset = 1'b1;
          state_nxt  = STREAM;
        end
        STREAM: begin
          r0_ready = !grant && !core_buffer_full;
          r1_ready =  grant && !core_buffer_full;
          if (g_valid && !core_buffer_full) begin
            core_in_ready = 1'b1;
            core_in       = g_data;
            core_is_last  = g_last;
            core_byte_num = g_byte_num;
            if (g_last) begin
              clr_wcnt  = 1'b1;
              state_nxt = WAIT;
            end
          end
        end
        WAIT: begin
          if (core_out_ready) begin
            cap_digest = 1'b1;
            state_nxt  = DELIVER;
          end else if (timeout_hit) begin
            timeout_err = 1'b1;
            core_reset  = 1'b1;
            flip_prio   = 1'b1;
            state_nxt   = IDLE;
          end
        end
        DELIVER: begin
          digest_valid = 1'b1;
          if (digest_ack) begin
            flip_prio = 1'b1;
            state_nxt = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      grant  <= 1'b0;
      prio   <= 1'b0;
      wcnt   <= '0;
      digest <= '0;
    end else begin
      if (load_grant) grant <= pick;
      if (flip_prio)  prio  <= ~grant;
      if (clr_wcnt)             wcnt <= '0;
      else if (state == WAIT)   wcnt <= wcnt + 16'd1;
      if (cap_digest) digest <= core_out;
    end
  end
endmodule

// File: tb/tb_keccak_arbiter.sv
// Bench for keccak_arbiter: behavioural core model plus a byte-string digest reference per requester.
module tb_keccak_arbiter;
  localparam int TO = 8;

  typedef struct packed {
    logic [31:0] d;
    logic        l;
    logic [1:0]  b;
  } wrd_t;

  typedef struct {
    int    req;
    string txt;
    int    words;
    int    bn;
  } vec_t;

  logic         clk, reset;
  logic         r0_valid, r0_last, r0_ready, r1_valid, r1_last, r1_ready;
  logic [31:0]  r0_data, r1_data;
  logic [1:0]   r0_byte_num, r1_byte_num;
  logic [511:0] digest;
  logic         digest_valid, digest_id, digest_ack, timeout_err, err_id;
  logic         core_reset, core_in_ready, core_is_last, core_buffer_full, core_out_ready;
  logic [31:0]  core_in;
  logic [1:0]   core_byte_num;
  logic [511:0] core_out;

  keccak_arbiter #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .r0_valid(r0_valid), .r0_data(r0_data), .r0_last(r0_last), .r0_byte_num(r0_byte_num), .r0_ready(r0_ready),
    .r1_valid(r1_valid), .r1_data(r1_data), .r1_last(r1_last), .r1_byte_num(r1_byte_num), .r1_ready(r1_ready),
    .digest(digest), .digest_valid(digest_valid), .digest_id(digest_id), .digest_ack(digest_ack),
    .timeout_err(timeout_err), .err_id(err_id),
    .core_reset(core_reset), .core_in(core_in), .core_in_ready(core_in_ready), .core_is_last(core_is_last),
    .core_byte_num(core_byte_num), .core_buffer_full(core_buffer_full),
    .core_out(core_out), .core_out_ready(core_out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks, n_err;
  wrd_t q0[$], q1[$];
  logic [511:0] exp0[$], exp1[$];
  logic [7:0]   cbytes[$];
  logic [31:0]  clog[$];
  logic [511:0] c_out;
  bit  c_or, never_resp, gap_rand, bf_rand, ack_rand, or_seen, dv_seen, tmo_creset;
  int  ccnt, bf_hold, cyc, t_lastx, t_tmo, t_or, t_dv, n_tmo, tmo_id, n_dv, r1_early, last_bn, n_deliv, n_bf;
  int  dl_ids[$];

  function automatic void chk(string name, logic [511:0] act, logic [511:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Reference digest over a plain byte string: independent of word framing.
  function automatic logic [511:0] hbytes(input logic [7:0] b[$]);
    logic [511:0] h;
    h = {16{32'h6a09e667}};
    for (int i = 0; i < b.size(); i++)
      h = {h[502:0], h[511:503]} ^ (512'(b[i]) << ((i * 8) % 504)) ^ 512'(i * 32'h9e3779b9 + 1);
    h = h ^ (512'(b.size()) << 256);
    return h;
  endfunction

  function automatic int pending();
    return q0.size() + q1.size() + exp0.size() + exp1.size();
  endfunction

  // Frame a byte string into words: full words, then a final word carrying the remainder (possibly zero bytes).
  task automatic frame(input int req, input logic [7:0] b[$], input bit want);
    int   nw;
    wrd_t w;
    nw = b.size() / 4 + 1;
    for (int k = 0; k < nw; k++) begin
      w.d = $urandom;
      w.l = (k == nw - 1);
      w.b = w.l ? 2'(b.size() % 4) : 2'($urandom);
      for (int j = 0; j < 4; j++)
        if (k * 4 + j < b.size()) w.d[31-8*j -: 8] = b[k*4+j];
      if (req == 0) q0.push_back(w);
      else          q1.push_back(w);
    end
    if (want) begin
      if (req == 0) exp0.push_back(hbytes(b));
      else          exp1.push_back(hbytes(b));
    end
  endtask

  task automatic tx_str(input int req, input string s, input bit want);
    logic [7:0] b[$];
    for (int i = 0; i < s.len(); i++) b.push_back(s[i]);
    frame(req, b, want);
  endtask

  task automatic drive();
    wrd_t w;
    if (ccnt > 0) ccnt--;
    if (ccnt == 0) begin
      c_or  = 1'b1;
      c_out = hbytes(cbytes);
      ccnt  = -1;
    end
    core_out_ready   = c_or;
    core_out         = c_or ? c_out : {16{$urandom}};
    core_buffer_full = (bf_hold > 0) || (bf_rand && ($urandom_range(3) == 0));
    if (bf_hold > 0) bf_hold--;
    digest_ack = ack_rand ? 1'($urandom_range(1)) : 1'b1;
    w = (q0.size() > 0) ? q0[0] : '0;
    r0_valid = (q0.size() > 0) && !(gap_rand && ($urandom_range(3) == 0));
    r0_data = w.d; r0_last = w.l; r0_byte_num = w.b;
    w = (q1.size() > 0) ? q1[0] : '0;
    r1_valid = (q1.size() > 0) && !(gap_rand && ($urandom_range(3) == 0));
    r1_data = w.d; r1_last = w.l; r1_byte_num = w.b;
  endtask

  // Observe the settled current cycle: invariants, core model, requester pops, scoreboard.
  task automatic process();
    int nb;
    chk("one_ready", r0_ready & r1_ready, 0);
    if (core_buffer_full) begin
      n_bf++;
      chk("bp_block", {r0_ready, r1_ready, core_in_ready}, 0);
    end
    if (!core_in_ready) chk("idle_core_bus", {core_in, core_is_last, core_byte_num}, 0);
    if (core_out_ready && !or_seen) begin or_seen = 1; t_or = cyc; end
    if (digest_valid && !dv_seen) begin dv_seen = 1; t_dv = cyc; end
    if (digest_valid) n_dv++;
    if (r1_ready && n_deliv == 0) r1_early++;
    if (timeout_err) begin n_tmo++; t_tmo = cyc; tmo_id = int'(err_id); tmo_creset = core_reset; end
    if (core_reset) begin
      cbytes.delete(); clog.delete(); ccnt = -1; c_or = 0; or_seen = 0; dv_seen = 0;
    end else if (core_in_ready) begin
      clog.push_back(core_in);
      nb = core_is_last ? int'(core_byte_num) : 4;
      for (int j = 0; j < nb; j++) cbytes.push_back(core_in[31-8*j -: 8]);
      if (core_is_last) begin
        ccnt    = never_resp ? -1 : int'($urandom_range(1, 5));
        t_lastx = cyc;
        last_bn = int'(core_byte_num);
      end
    end
    if (r0_valid && r0_ready) void'(q0.pop_front());
    if (r1_valid && r1_ready) void'(q1.pop_front());
    if (digest_valid && digest_ack) begin
      n_deliv++;
      dl_ids.push_back(int'(digest_id));
      if (digest_id == 1'b0 && exp0.size() > 0)      chk("digest_r0", digest, exp0.pop_front());
      else if (digest_id == 1'b1 && exp1.size() > 0) chk("digest_r1", digest, exp1.pop_front());
      else begin
        n_checks++; n_err++;
        $display("FAIL digest_owner: got unexpected digest for requester %0d", digest_id);
      end
    end
  endtask

  task automatic tick();
    process();
    @(posedge clk);
    @(negedge clk);
    cyc++;
    drive();
    #1;
  endtask

  task automatic wait_done(input int budget, input string name);
    for (int i = 0; i < budget && pending() != 0; i++) tick();
    chk(name, pending(), 0);
  endtask

  initial begin
    vec_t       tab[5];
    logic [7:0] b[$];
    string      fox;
    logic [31:0] fw;
    int         base;

    tab[0] = '{0, "Hello, world!",  4, 1};
    tab[1] = '{0, "Hello, world",   4, 0};
    tab[2] = '{1, "abc",            1, 3};
    tab[3] = '{1, "",               1, 0};
    tab[4] = '{1, "Keccak arbiter", 4, 2};
    fox = "The quick brown fox jumps over the lazy dog.";

    n_checks = 0; n_err = 0; cyc = 0; ccnt = -1; bf_hold = 0; c_or = 0; c_out = '0;
    never_resp = 0; gap_rand = 0; bf_rand = 0; ack_rand = 0; or_seen = 0; dv_seen = 0;
    n_tmo = 0; n_dv = 0; n_deliv = 0; n_bf = 0; r1_early = 0; tmo_creset = 0;
    t_lastx = 0; t_tmo = 0; t_or = 0; t_dv = 0; tmo_id = 0; last_bn = 0;
    reset = 1'b0;
    r0_valid = 0; r1_valid = 0; r0_data = 0; r1_data = 0; r0_last = 0; r1_last = 0;
    r0_byte_num = 0; r1_byte_num = 0; digest_ack = 0; core_buffer_full = 0; core_out_ready = 0; core_out = '0;

    // Reset with a requester already waiting, then start latency of the first message.
    tx_str(0, "Hello, world!", 1);
    @(negedge clk); drive(); #1;
    chk("rst_core_reset", core_reset, 1);
    chk("rst_r0_ready", r0_ready, 0);
    chk("rst_digest_valid", digest_valid, 0);
    chk("rst_core_in_ready", core_in_ready, 0);
    chk("rst_timeout_err", timeout_err, 0);
    tick(); tick();
    chk("rst_digest", digest, 0);
    reset = 1'b1; #1;
    chk("idle_r0_ready", r0_ready, 0);
    chk("idle_core_reset", core_reset, 0);
    tick();
    chk("clear_pulse", core_reset, 1);
    chk("clear_r0_ready", r0_ready, 0);
    tick();
    chk("first_r0_ready", r0_ready, 1);
    chk("first_strobe", core_in_ready, 1);
    chk("first_word", core_in, 32'h48656c6c);
    wait_done(200, "drain_single");
    chk("single_strobes", clog.size(), 4);
    chk("single_id", dl_ids[dl_ids.size()-1], 0);
    chk("single_dv_latency", t_dv, t_or + 1);

    // Directed messages, one requester at a time.
    for (int v = 0; v < 5; v++) begin
      tx_str(tab[v].req, tab[v].txt, 1);
      wait_done(200, "drain_table");
      chk("tab_words", clog.size(), tab[v].words);
      chk("tab_last_bn", last_bn, tab[v].bn);
      chk("tab_id", dl_ids[dl_ids.size()-1], tab[v].req);
      chk("tab_dv_latency", t_dv, t_or + 1);
    end

    // Contention with prio=0: r0 first, r1 held off, then r1.
    dl_ids.delete(); n_deliv = 0; r1_early = 0;
    tx_str(0, "first one", 1);
    tx_str(1, "second one", 1);
    wait_done(300, "drain_contention");
    chk("cont_order0", dl_ids[0], 0);
    chk("cont_order1", dl_ids[1], 1);
    chk("cont_r1_held", r1_early, 0);

    // Back-pressure: 5 full cycles mid-message on an 11-word message ending in a zero-byte word.
    for (int k = 0; k < 11; k++) begin
      fw = {fox[4*k], fox[4*k+1], fox[4*k+2], fox[4*k+3]};
      q0.push_back('{d: fw, l: (k == 10), b: 2'd0});
    end
    b.delete();
    for (int i = 0; i < 40; i++) b.push_back(fox[i]);
    exp0.push_back(hbytes(b));
    for (int i = 0; i < 60 && clog.size() < 3; i++) tick();
    chk("bp_started", clog.size() >= 3, 1);
    n_bf = 0; bf_hold = 5;
    wait_done(300, "drain_bp");
    chk("bp_full_cycles", n_bf, 5);
    chk("bp_strobes", clog.size(), 11);
    for (int k = 0; k < 11 && k < clog.size(); k++)
      chk("bp_word", clog[k], {fox[4*k], fox[4*k+1], fox[4*k+2], fox[4*k+3]});

    // Watchdog: core never answers; r1 is granted (prio=1 after r0 was served).
    never_resp = 1; n_dv = 0; n_tmo = 0;
    tx_str(1, "xy", 0);
    for (int i = 0; i < 80 && n_tmo == 0; i++) tick();
    chk("tmo_seen", n_tmo, 1);
    chk("tmo_delay", t_tmo - t_lastx, TO);
    chk("tmo_err_id", tmo_id, 1);
    chk("tmo_core_reset", tmo_creset, 1);
    for (int i = 0; i < 5; i++) tick();
    chk("tmo_single_pulse", n_tmo, 1);
    chk("tmo_no_digest", n_dv, 0);
    never_resp = 0;
    tx_str(0, "after timeout", 1);
    wait_done(200, "drain_after_tmo");
    chk("after_tmo_id", dl_ids[dl_ids.size()-1], 0);

    // Mid-message reset while prio=1; after release prio must be back at 0.
    b.delete();
    for (int i = 0; i < 20; i++) b.push_back(8'($urandom));
    frame(0, b, 1);
    for (int i = 0; i < 60 && clog.size() < 2; i++) tick();
    chk("mrst_started", clog.size() >= 2, 1);
    reset = 1'b0; q0.delete(); exp0.delete(); #1;
    chk("mrst_ready_a", {r0_ready, r1_ready}, 0);
    chk("mrst_core_reset_a", core_reset, 1);
    chk("mrst_strobe_a", core_in_ready, 0);
    tick();
    chk("mrst_ready_b", {r0_ready, r1_ready}, 0);
    chk("mrst_core_reset_b", core_reset, 1);
    tick();
    reset = 1'b1; #1;
    chk("mrst_idle_ready", r0_ready, 0);
    chk("mrst_idle_core_reset", core_reset, 0);
    dl_ids.delete();
    tx_str(1, "B side", 1);
    tx_str(0, "A side fresh", 1);
    wait_done(300, "drain_mrst");
    chk("mrst_prio_order0", dl_ids[0], 0);
    chk("mrst_prio_order1", dl_ids[1], 1);

    // Randomized traffic against the per-requester byte-string scoreboard.
    gap_rand = 1; bf_rand = 1; ack_rand = 1; n_tmo = 0;
    base = n_deliv;
    for (int m = 0; m < 40; m++) begin
      b.delete();
      for (int i = 0; i < int'($urandom_range(22)); i++) b.push_back(8'($urandom));
      frame(int'($urandom_range(1)), b, 1);
    end
    wait_done(20000, "drain_random");
    chk("rand_deliveries", n_deliv - base, 40);
    chk("rand_no_timeout", n_tmo, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1);
  end
endmodule
